// File: rtl/serial_link_pkg.sv
// Shared Serial Link definitions: lane count, PHY word type and the
// transmit-channel state encoding used by the PHY stage.
package serial_link_pkg;

  localparam int NumLanes    = 4;
  localparam int ClkDivWidth = 8;

  typedef logic [2*NumLanes-1:0] phy_data_t;

  typedef enum logic {
    PhyTxIdle = 1'b0,
    PhyTxBusy = 1'b1
  } phy_tx_state_e;

endpackage

// File: rtl/serial_link_phy_tx_channel.sv
// Transmit PHY stage for one Serial Link channel. Each accepted word is sent
// as two half-words (low half first) over one forwarded-clock period of D
// clk_i cycles. The forwarded clock is high for D/2 cycles starting at
// offset S.
//
// Handshake: a word is transferred on a rising clk_i edge where
// valid_i & ready_o. ready_o is purely a decode of the current state and
// cfg_clk_ena_i; it never depends on valid_i. Once valid_i is raised the
// source keeps data_i stable until the transfer happens.
module serial_link_phy_tx_channel #(
  parameter int  NumLanes    = serial_link_pkg::NumLanes,
  parameter type phy_data_t  = serial_link_pkg::phy_data_t,
  parameter int  ClkDivWidth = serial_link_pkg::ClkDivWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  phy_data_t              data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   cfg_clk_ena_i,
  input  logic [ClkDivWidth-1:0] cfg_clk_div_i,
  input  logic [ClkDivWidth-1:0] cfg_clk_shift_i,
  output logic                   ddr_clk_o,
  output logic [NumLanes-1:0]    ddr_data_o
);

  import serial_link_pkg::phy_tx_state_e;
  import serial_link_pkg::PhyTxIdle;
  import serial_link_pkg::PhyTxBusy;

  localparam int W = ClkDivWidth;
  typedef logic [W-1:0] cnt_t;

  // Even period of at least two cycles so both halves get >= 1 cycle.
  function automatic cnt_t sanitise_div(input cnt_t d);
    cnt_t r;
    r = {d[W-1:1], 1'b0};
    if (r < cnt_t'(2)) r = cnt_t'(2);
    return r;
  endfunction

  // Shift kept below D/2 so the clock always falls inside the period.
  function automatic cnt_t sanitise_shift(input cnt_t s, input cnt_t d_even);
    cnt_t half;
    half = d_even >> 1;
    if (s >= half) return half - cnt_t'(1);
    return s;
  endfunction

  phy_tx_state_e             state_q, state_d;
  cnt_t                      k_q, k_d;
  cnt_t                      div_q, div_d;
  cnt_t                      shift_q, shift_d;
  logic [2*NumLanes-1:0]     word_q, word_d;
  logic                      ddr_clk_q, ddr_clk_d;
  logic [NumLanes-1:0]       ddr_data_q, ddr_data_d;

  logic                      last_cycle;
  logic                      handshake;
  cnt_t                      half_d;
  logic [W:0]                clk_fall_d;

  // Output decode: ready only in Idle or in the final cycle of a period.
  always_comb begin
    last_cycle = (state_q == PhyTxBusy) && (k_q == (div_q - cnt_t'(1)));
    ready_o    = cfg_clk_ena_i && ((state_q == PhyTxIdle) || last_cycle);
  end

  assign handshake = valid_i && ready_o;

  // Next-state logic, including precomputed lane/clock values for the flops.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    div_d      = div_q;
    shift_d    = shift_q;
    word_d     = word_q;
    half_d     = '0;
    clk_fall_d = '0;
    ddr_clk_d  = 1'b0;
    ddr_data_d = '0;

    if (handshake) begin
      // Idle accept and back-to-back accept in the last cycle look the same.
      state_d = PhyTxBusy;
      k_d     = '0;
      word_d  = data_i;
      div_d   = sanitise_div(cfg_clk_div_i);
      shift_d = sanitise_shift(cfg_clk_shift_i, div_d);
    end else if (state_q == PhyTxBusy) begin
      if (last_cycle) begin
        state_d = PhyTxIdle;
        k_d     = '0;
      end else begin
        k_d = k_q + cnt_t'(1);
      end
    end

    if (state_d == PhyTxBusy) begin
      half_d     = div_d >> 1;
      clk_fall_d = {1'b0, shift_d} + {1'b0, half_d};
      ddr_data_d = (k_d < half_d) ? word_d[NumLanes-1:0]
                                  : word_d[2*NumLanes-1:NumLanes];
      ddr_clk_d  = (k_d >= shift_d) && ({1'b0, k_d} < clk_fall_d);
    end
  end

  // State, counter, latched word/config and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= PhyTxIdle;
      k_q        <= '0;
      div_q      <= cnt_t'(2);
      shift_q    <= '0;
      word_q     <= '0;
      ddr_clk_q  <= 1'b0;
      ddr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      ddr_clk_q  <= ddr_clk_d;
      ddr_data_q <= ddr_data_d;
    end
  end

  assign ddr_clk_o  = ddr_clk_q;
  assign ddr_data_o = ddr_data_q;

endmodule

// File: doc/serial_link_phy_tx_channel.md
# serial_link_phy_tx_channel

Transmit-side physical stage for one Serial Link channel, directly downstream of the data link layer. It consumes one `phy_data_t` word per valid/ready handshake and drives it onto `NumLanes` output lanes as two half-words, low half first, at double data rate. Both halves sit under one generated source-synchronous forwarded clock. The forwarded clock is derived from `clk_i` by a runtime-configurable integer divider with a configurable phase shift. One instance is built per channel.

## Interface
Parameters:
- `NumLanes`, default `serial_link_pkg::NumLanes`: number of data lanes in the channel.
- `phy_data_t`, default `serial_link_pkg::phy_data_t`: word type, width `2*NumLanes`.
- `ClkDivWidth`, default 8: width of the divider and shift configuration fields and of the internal counter.

Ports:
- `clk_i`  in  1: system clock, single clock domain.
- `rst_ni`  in  1: asynchronous reset, active-low.
- `data_i`  in  `2*NumLanes`: word from the data link layer.
- `valid_i`  in  1: `data_i` valid.
- `ready_o`  out  1: word accepted when `valid_i & ready_o`.
- `cfg_clk_ena_i`  in  1: enables acceptance of new words.
- `cfg_clk_div_i`  in  `ClkDivWidth`: forwarded clock period D, counted in `clk_i` cycles.
- `cfg_clk_shift_i`  in  `ClkDivWidth`: forwarded clock rising-edge offset S, counted in `clk_i` cycles.
- `ddr_clk_o`  out  1: forwarded clock, registered.
- `ddr_data_o`  out  `NumLanes`: lane data, registered.

## Operation
- **States.** There are two states, Idle and Busy. Reset enters Idle.
- **Idle.**
  - `ddr_clk_o` = 0 and `ddr_data_o` = 0.
  - `ready_o` = `cfg_clk_ena_i`, combinational.
  - On handshake, capture the word, latch D and S, clear the period counter k, and go to Busy.
- **Busy.** Counter k runs from 0 to D-1, one step per cycle. In period cycle k:
  - `ddr_data_o` = `word[NumLanes-1:0]` when k < D/2, otherwise `word[2*NumLanes-1:NumLanes]`.
  - `ddr_clk_o` = 1 when S ≤ k < S + D/2, otherwise 0.
- **Last cycle of the period (k = D-1).**
  - `ready_o` = `cfg_clk_ena_i`.
  - On handshake: capture the next word, relatch D and S, and set k to 0 with no gap cycle.
  - Without handshake: go to Idle.
- **`ready_o` elsewhere.** `ready_o` = 0 in every other Busy cycle.
- **Config sanitising.** D and S are sanitised at latch time:
  - Odd D is rounded down to even.
  - D < 2 is forced to 2.
  - S ≥ D/2 is clamped to D/2 - 1.
  - This guarantees the forwarded clock falls before the period ends. The clock is therefore low on every return to Idle.
- **Config stability.** Configuration changes while Busy have no effect on the word in flight.
- **Enable deassertion.** Deasserting `cfg_clk_ena_i` while Busy finishes the current period, then enters Idle.
- **Reset.** Asserting `rst_ni` low mid-word immediately forces:
  - Idle state, k = 0, `ddr_clk_o` = 0, `ddr_data_o` = 0.
  - The word in flight is discarded.

## Timing
- **Outputs.** `ddr_clk_o` and `ddr_data_o` come straight from flops and are glitch-free. The next-state logic precomputes their values.
- **Start of a period.** Period cycle k = 0 is the first cycle after the accepting edge.
- **Latency.** The first lane data appears 1 cycle after the handshake.
- **Throughput.** One word per D cycles, with back-to-back words seamless.
- **Reset values.**
  - `ddr_clk_o` = 0 and `ddr_data_o` = 0.
  - `ready_o` follows `cfg_clk_ena_i`, because the state is Idle.
- **Edge placement.** Data changes at k = 0 and k = D/2. Clock edges fall at S and S + D/2. S therefore sets the data-to-clock skew; S = D/4 centres the edge.
- **Widths.** The counter is `ClkDivWidth` bits wide. D/2 is computed as `D >> 1`. The comparison `S + D/2` uses `ClkDivWidth+1` bits, so it cannot overflow.

## Structure
- `phy_data_t` and `NumLanes` come from `serial_link_pkg`.
- Add the following to `serial_link_pkg`:
  - a state enum `phy_tx_state_e` with values `PhyTxIdle` and `PhyTxBusy`;
  - a default `ClkDivWidth` constant.
- The block is a single module with no sub-module. The divider and counter are too small to split out.
- State and counter use the `FF` register macro with asynchronous reset.

## Test plan
- **Single word.** `NumLanes` = 4, D = 4, S = 1, send `8'hA5` from Idle.
  - Data 4'h5 in cycles 0-1, then 4'hA in cycles 2-3.
  - `ddr_clk_o` high in cycles 1-2.
  - Then Idle with both outputs 0.
- **Back-to-back.** `valid_i` held high with `8'h12`, then `8'h34`, D = 4.
  - `ready_o` pulses every 4th cycle.
  - Lane sequence 2,2,1,1,4,4,3,3 with no gap.
  - The clock runs continuously.
- **Sanitising.** D = 5, S = 3.
  - Behaves exactly as D = 4, S = 1.
  - D = 0 behaves as D = 2, S = 0: clock high in cycle 0 only.
- **Config change mid-word.** Change D from 8 to 4 at k = 2.
  - The current word still spans 8 cycles.
  - The next accepted word spans 4 cycles.
- **Enable drop.** `cfg_clk_ena_i` = 0 mid-period.
  - The period completes.
  - `ready_o` stays 0 and the block enters Idle with `ddr_clk_o` = 0.
- **Reset mid-word.** `rst_ni` pulled low at k = 1.
  - Outputs are 0 in the same cycle.
  - After release, a new word starts cleanly at k = 0.
